// File: rtl/audio_pdm_tx.sv
// audio_pdm_tx: FIFO-buffered PCM samples to first-order sigma-delta PDM speaker pins
module audio_pdm_tx #(
  parameter int CLK_DIV = 32,
  parameter int OSR = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int IDLE_SAMPLES = 256,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          data_spk_valid_i,
  input  logic [15:0]   data_spk_i,
  output logic          data_spk_ready_o,
  output logic          pwm_audio_o,
  output logic          pwm_sdaudio_o,
  output logic          underrun_o,
  output logic [LW-1:0] fifo_level_o
);
  localparam int AW = LW - 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(OSR);
  localparam int EW = $clog2(IDLE_SAMPLES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [BW-1:0] bitcnt;
  logic [EW-1:0] empty_cnt, empty_cnt_n;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic [15:0] held, held_n, acc;
  logic [16:0] sum;
  logic bit_tick, sample_tick, wr, pop, empty, underrun_n;
  assign bit_tick = div == DW'(CLK_DIV - 1);
  assign sample_tick = bit_tick && bitcnt == BW'(OSR - 1);
  assign empty = level == '0;
  assign data_spk_ready_o = level != LW'(FIFO_DEPTH);
  assign wr = enable_i && data_spk_valid_i && data_spk_ready_o;
  assign sum = {1'b0, acc} + {1'b0, held ^ 16'h8000};
  assign fifo_level_o = level;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    held_n = held;
    empty_cnt_n = empty_cnt;
    underrun_n = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      empty_cnt_n = '0;
    end else if (sample_tick) begin
      if (state == IDLE) begin
        if (level >= LW'(PRIME_LEVEL)) begin
          pop = 1'b1;
          held_n = mem[rptr];
          empty_cnt_n = '0;
          state_n = RUN;
        end
      end else if (!empty) begin
        pop = 1'b1;
        held_n = mem[rptr];
        empty_cnt_n = '0;
      end else begin
        held_n = '0;
        underrun_n = 1'b1;
        empty_cnt_n = empty_cnt + 1'b1;
        if (empty_cnt_n == EW'(IDLE_SAMPLES)) begin
          state_n = IDLE;
          empty_cnt_n = '0;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      div <= '0;
      bitcnt <= '0;
      empty_cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      held <= '0;
      acc <= '0;
      pwm_audio_o <= 1'b0;
      pwm_sdaudio_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      state <= state_n;
      div <= bit_tick ? '0 : div + 1'b1;
      if (bit_tick) bitcnt <= (bitcnt == BW'(OSR - 1)) ? '0 : bitcnt + 1'b1;
      empty_cnt <= empty_cnt_n;
      held <= held_n;
      underrun_o <= underrun_n;
      pwm_sdaudio_o <= state_n == RUN;
      if (!enable_i) begin
        wptr <= '0;
        rptr <= '0;
        level <= '0;
      end else begin
        wptr <= wptr + AW'(wr);
        rptr <= rptr + AW'(pop);
        level <= level + LW'(wr) - LW'(pop);
      end
      if (state_n != RUN) begin
        acc <= '0;
        pwm_audio_o <= 1'b0;
      end else if (state == RUN && bit_tick) begin
        acc <= sum[15:0];
        pwm_audio_o <= sum[16];
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= data_spk_i;
  end
endmodule
